// File: rtl/motion_sequencer.sv
// Two-wheel motion sequencer: ramps a shared speed setpoint up to cruise, holds it,
// ramps down near the target distance, and trims the leading wheel to keep both in step.
module motion_sequencer #(
  parameter logic [31:0] RAMP_TICKS   = 32'd160000,
  parameter logic [15:0] RAMP_STEP    = 16'd40,
  parameter logic [15:0] MAX_DEG_S    = 16'd1440,
  parameter logic [15:0] DECEL_PULSES = 16'd20,
  parameter logic [15:0] TRIM         = 16'd16
) (
  input  logic        clk,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_pulses,
  input  logic [15:0] cmd_deg_s,
  input  logic        abort,
  input  logic        enc_l,
  input  logic        enc_r,
  output logic        ctl_en,
  output logic [15:0] deg_s_l,
  output logic [15:0] deg_s_r,
  output logic        busy,
  output logic        done,
  output logic [15:0] pulses_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] curSpeed_q, curSpeed_d;
  logic [15:0] cruise_q, cruise_d;
  logic [15:0] target_q, target_d;
  logic [15:0] countL_q, countL_d;
  logic [15:0] countR_q, countR_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  syncL_q, syncR_q;

  logic        riseL, riseR, running, tick, nearEnd;
  logic [16:0] accelSum;
  logic [15:0] trimmed;

  // Bits [1:0] are the synchronizer, bit [2] holds the previous sample for edge detection.
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      syncL_q <= 3'b000;
      syncR_q <= 3'b000;
    end else begin
      syncL_q <= {syncL_q[1:0], enc_l};
      syncR_q <= {syncR_q[1:0], enc_r};
    end
  end

  assign riseL    = syncL_q[1] & ~syncL_q[2];
  assign riseR    = syncR_q[1] & ~syncR_q[2];
  assign running  = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);
  assign tick     = (timer_q >= (RAMP_TICKS - 32'd1));
  assign accelSum = {1'b0, curSpeed_q} + {1'b0, RAMP_STEP};
  // Written as count+threshold >= target so an overshoot past target cannot wrap the remainder.
  assign nearEnd  = ({1'b0, countL_q} + {1'b0, DECEL_PULSES}) >= {1'b0, target_q};

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      state_q    <= IDLE;
      curSpeed_q <= 16'd0;
      cruise_q   <= 16'd0;
      target_q   <= 16'd0;
      countL_q   <= 16'd0;
      countR_q   <= 16'd0;
      timer_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      curSpeed_q <= curSpeed_d;
      cruise_q   <= cruise_d;
      target_q   <= target_d;
      countL_q   <= countL_d;
      countR_q   <= countR_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    curSpeed_d = curSpeed_q;
    cruise_d   = cruise_q;
    target_d   = target_q;
    countL_d   = countL_q;
    countR_d   = countR_q;
    timer_d    = timer_q + 32'd1;

    if (running && riseL && (countL_q != 16'hFFFF)) countL_d = countL_q + 16'd1;
    if (running && riseR && (countR_q != 16'hFFFF)) countR_d = countR_q + 16'd1;

    case (state_q)
      IDLE: begin
        timer_d = 32'd0;
        if (cmd_valid) begin
          target_d   = cmd_pulses;
          cruise_d   = (cmd_deg_s > MAX_DEG_S) ? MAX_DEG_S : cmd_deg_s;
          countL_d   = 16'd0;
          countR_d   = 16'd0;
          curSpeed_d = 16'd0;
          state_d    = (cmd_pulses == 16'd0) ? STOP : ACCEL;
        end
      end
      ACCEL: begin
        if (tick) begin
          timer_d    = 32'd0;
          curSpeed_d = (accelSum >= {1'b0, cruise_q}) ? cruise_q : accelSum[15:0];
        end
        if (nearEnd || abort) state_d = DECEL;
        else if (tick && (accelSum >= {1'b0, cruise_q})) state_d = CRUISE;
      end
      CRUISE: begin
        if (nearEnd || abort) state_d = DECEL;
      end
      DECEL: begin
        if (tick) begin
          timer_d    = 32'd0;
          curSpeed_d = (curSpeed_q > RAMP_STEP) ? (curSpeed_q - RAMP_STEP) : 16'd0;
        end
        if ((countL_q >= target_q) || (curSpeed_q == 16'd0)) state_d = STOP;
      end
      STOP: begin
        timer_d = 32'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) timer_d = 32'd0;
  end

  always_comb begin
    cmd_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    done        = (state_q == STOP);
    ctl_en      = running;
    pulses_done = countL_q;
    trimmed     = (curSpeed_q > TRIM) ? (curSpeed_q - TRIM) : 16'd0;
    deg_s_l     = 16'd0;
    deg_s_r     = 16'd0;
    if (running) begin
      deg_s_l = (countL_q > countR_q) ? trimmed : curSpeed_q;
      deg_s_r = (countR_q > countL_q) ? trimmed : curSpeed_q;
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with a short ramp period so moves finish quickly.
module tb_motion_sequencer;

  logic        clk = 1'b0;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_pulses;
  logic [15:0] cmd_deg_s;
  logic        abort;
  logic        enc_l;
  logic        enc_r;
  logic        ctl_en;
  logic [15:0] deg_s_l;
  logic [15:0] deg_s_r;
  logic        busy;
  logic        done;
  logic [15:0] pulses_done;

  int vectors = 0;
  int miscompares = 0;

  motion_sequencer #(.RAMP_TICKS(32'd10)) dut (
    .clk(clk), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pulses(cmd_pulses), .cmd_deg_s(cmd_deg_s), .abort(abort),
    .enc_l(enc_l), .enc_r(enc_r), .ctl_en(ctl_en), .deg_s_l(deg_s_l),
    .deg_s_r(deg_s_r), .busy(busy), .done(done), .pulses_done(pulses_done)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [15:0] p, input logic [15:0] s);
    cmd_pulses = p;
    cmd_deg_s  = s;
    cmd_valid  = 1'b1;
    cyc();
    cmd_valid  = 1'b0;
  endtask

  // One encoder edge every two cycles; no flush afterwards.
  task automatic enc_pulses(input int n, input logic dl, input logic dr);
    for (int i = 0; i < n; i++) begin
      enc_l = dl;
      enc_r = dr;
      cyc();
      enc_l = 1'b0;
      enc_r = 1'b0;
      cyc();
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    cmd_valid = 1'b0; cmd_pulses = 16'd0; cmd_deg_s = 16'd0;
    abort = 1'b0; enc_l = 1'b0; enc_r = 1'b0;
    cyc();
    vectors++; if (ctl_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ctl_en: got %0d expected 0", ctl_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0d expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0d expected 0", done); end
    vectors++; if (deg_s_l !== 16'd0 || deg_s_r !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_deg_s: got %0d/%0d expected 0/0", deg_s_l, deg_s_r); end
    vectors++; if (pulses_done !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_pulses_done: got %0d expected 0", pulses_done); end
    cyc();
    enable = 1'b1;
    cyc();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cmd_ready: got %0d expected 1", cmd_ready); end
  endtask

  task automatic test_accel();
    start_cmd(16'd200, 16'd400);
    vectors++; if (ctl_en !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL accel_entry: got ctl_en=%0d busy=%0d ready=%0d expected 1 1 0", ctl_en, busy, cmd_ready); end
    for (int k = 1; k <= 10; k++) begin
      repeat (9) cyc();
      if (k == 5) begin
        cmd_valid = 1'b1; cmd_pulses = 16'd7; cmd_deg_s = 16'd100;
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_cmd_ready: got %0d expected 0", cmd_ready); end
      end
      vectors++; if (deg_s_l !== 16'(40 * (k - 1))) begin miscompares++; $display("[TB] FAIL accel_hold_%0d: got %0d expected %0d", k, deg_s_l, 40 * (k - 1)); end
      cyc();
      cmd_valid = 1'b0;
      vectors++; if (deg_s_l !== 16'(40 * k) || deg_s_r !== 16'(40 * k)) begin miscompares++; $display("[TB] FAIL accel_step_%0d: got %0d/%0d expected %0d", k, deg_s_l, deg_s_r, 40 * k); end
    end
    repeat (15) cyc();
    vectors++; if (deg_s_l !== 16'd400 || ctl_en !== 1'b1) begin miscompares++; $display("[TB] FAIL cruise_hold: got %0d en=%0d expected 400 en=1", deg_s_l, ctl_en); end
  endtask

  task automatic test_trim();
    enc_pulses(3, 1'b1, 1'b0); repeat (3) cyc();
    vectors++; if (deg_s_l !== 16'd384 || deg_s_r !== 16'd400) begin miscompares++; $display("[TB] FAIL trim_left_lead: got %0d/%0d expected 384/400", deg_s_l, deg_s_r); end
    vectors++; if (pulses_done !== 16'd3) begin miscompares++; $display("[TB] FAIL trim_count: got %0d expected 3", pulses_done); end
    enc_pulses(3, 1'b0, 1'b1); repeat (3) cyc();
    vectors++; if (deg_s_l !== 16'd400 || deg_s_r !== 16'd400) begin miscompares++; $display("[TB] FAIL trim_equal: got %0d/%0d expected 400/400", deg_s_l, deg_s_r); end
    enc_pulses(2, 1'b0, 1'b1); repeat (3) cyc();
    vectors++; if (deg_s_l !== 16'd400 || deg_s_r !== 16'd384) begin miscompares++; $display("[TB] FAIL trim_right_lead: got %0d/%0d expected 400/384", deg_s_l, deg_s_r); end
    enc_pulses(2, 1'b1, 1'b0); repeat (3) cyc();
    vectors++; if (deg_s_l !== 16'd400 || deg_s_r !== 16'd400 || pulses_done !== 16'd5) begin miscompares++; $display("[TB] FAIL trim_rebalance: got %0d/%0d cnt=%0d expected 400/400 cnt=5", deg_s_l, deg_s_r, pulses_done); end
  endtask

  task automatic test_abort();
    int n;
    enc_pulses(45, 1'b1, 1'b1); repeat (3) cyc();
    vectors++; if (pulses_done !== 16'd50 || deg_s_l !== 16'd400) begin miscompares++; $display("[TB] FAIL abort_pre: got cnt=%0d spd=%0d expected 50/400", pulses_done, deg_s_l); end
    abort = 1'b1;
    cyc();
    repeat (9) cyc();
    vectors++; if (deg_s_l !== 16'd400) begin miscompares++; $display("[TB] FAIL abort_decel_hold: got %0d expected 400", deg_s_l); end
    cyc();
    vectors++; if (deg_s_l !== 16'd360) begin miscompares++; $display("[TB] FAIL abort_decel_step: got %0d expected 360", deg_s_l); end
    n = 11;
    while (!done && n < 200) begin cyc(); n++; end
    vectors++; if (done !== 1'b1 || n != 102) begin miscompares++; $display("[TB] FAIL abort_done_time: got done=%0d at %0d expected done=1 at 102", done, n); end
    vectors++; if (ctl_en !== 1'b0 || deg_s_l !== 16'd0 || deg_s_r !== 16'd0) begin miscompares++; $display("[TB] FAIL stop_outputs: got en=%0d %0d/%0d expected 0 0/0", ctl_en, deg_s_l, deg_s_r); end
    cyc();
    abort = 1'b0;
    vectors++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_after: got done=%0d busy=%0d ready=%0d expected 0 0 1", done, busy, cmd_ready); end
    vectors++; if (pulses_done !== 16'd50) begin miscompares++; $display("[TB] FAIL abort_pulses_done: got %0d expected 50", pulses_done); end
  endtask

  task automatic test_idle();
    enc_pulses(3, 1'b1, 1'b1);
    abort = 1'b1;
    repeat (5) cyc();
    abort = 1'b0;
    vectors++; if (pulses_done !== 16'd50) begin miscompares++; $display("[TB] FAIL idle_no_count: got %0d expected 50", pulses_done); end
    vectors++; if (busy !== 1'b0 || ctl_en !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_state: got busy=%0d en=%0d ready=%0d expected 0 0 1", busy, ctl_en, cmd_ready); end
  endtask

  task automatic test_full_move();
    int n;
    start_cmd(16'd200, 16'd400);
    vectors++; if (pulses_done !== 16'd0) begin miscompares++; $display("[TB] FAIL full_clear: got %0d expected 0", pulses_done); end
    repeat (100) cyc();
    enc_pulses(180, 1'b1, 1'b1); repeat (3) cyc();
    vectors++; if (pulses_done !== 16'd180) begin miscompares++; $display("[TB] FAIL full_count180: got %0d expected 180", pulses_done); end
    repeat (8) cyc();
    vectors++; if (deg_s_l !== 16'd400) begin miscompares++; $display("[TB] FAIL full_decel_hold: got %0d expected 400", deg_s_l); end
    cyc();
    vectors++; if (deg_s_l !== 16'd360) begin miscompares++; $display("[TB] FAIL full_decel_step: got %0d expected 360", deg_s_l); end
    enc_pulses(20, 1'b1, 1'b1);
    vectors++; if (deg_s_l !== 16'd200 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL full_decel_late: got %0d done=%0d expected 200 done=0", deg_s_l, done); end
    n = 0;
    while (!done && n < 20) begin cyc(); n++; end
    vectors++; if (done !== 1'b1 || pulses_done !== 16'd200) begin miscompares++; $display("[TB] FAIL full_done: got done=%0d cnt=%0d expected 1/200", done, pulses_done); end
    cyc();
    vectors++; if (done !== 1'b0 || busy !== 1'b0 || pulses_done !== 16'd200) begin miscompares++; $display("[TB] FAIL full_after: got done=%0d busy=%0d cnt=%0d expected 0 0 200", done, busy, pulses_done); end
  endtask

  task automatic test_zero_pulses();
    start_cmd(16'd0, 16'd400);
    vectors++; if (done !== 1'b1 || ctl_en !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_stop: got done=%0d en=%0d busy=%0d expected 1 0 1", done, ctl_en, busy); end
    cyc();
    vectors++; if (done !== 1'b0 || ctl_en !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_idle: got done=%0d en=%0d busy=%0d expected 0 0 0", done, ctl_en, busy); end
  endtask

  task automatic test_clamp();
    int n;
    start_cmd(16'd1000, 16'd2000);
    repeat (350) cyc();
    vectors++; if (deg_s_l !== 16'd1400) begin miscompares++; $display("[TB] FAIL clamp_ramp: got %0d expected 1400", deg_s_l); end
    repeat (10) cyc();
    vectors++; if (deg_s_l !== 16'd1440) begin miscompares++; $display("[TB] FAIL clamp_reach: got %0d expected 1440", deg_s_l); end
    repeat (20) cyc();
    vectors++; if (deg_s_l !== 16'd1440 || deg_s_r !== 16'd1440) begin miscompares++; $display("[TB] FAIL clamp_hold: got %0d/%0d expected 1440/1440", deg_s_l, deg_s_r); end
    abort = 1'b1;
    n = 0;
    while (!done && n < 600) begin cyc(); n++; end
    abort = 1'b0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL clamp_abort_done: got %0d expected 1 within 600 cycles", done); end
    cyc();
  endtask

  task automatic test_reset_mid();
    int doneSeen;
    start_cmd(16'd200, 16'd400);
    enc_pulses(3, 1'b1, 1'b1); repeat (3) cyc();
    repeat (12) cyc();
    vectors++; if (deg_s_l !== 16'd80 || pulses_done !== 16'd3) begin miscompares++; $display("[TB] FAIL mid_pre: got spd=%0d cnt=%0d expected 80/3", deg_s_l, pulses_done); end
    enable = 1'b0;
    #1;
    vectors++; if (ctl_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_ctl: got en=%0d busy=%0d done=%0d expected 0 0 0", ctl_en, busy, done); end
    vectors++; if (deg_s_l !== 16'd0 || deg_s_r !== 16'd0 || pulses_done !== 16'd0) begin miscompares++; $display("[TB] FAIL mid_reset_data: got %0d/%0d cnt=%0d expected 0/0 cnt=0", deg_s_l, deg_s_r, pulses_done); end
    doneSeen = 0;
    repeat (2) begin cyc(); if (done) doneSeen++; end
    enable = 1'b1;
    repeat (20) begin cyc(); if (done) doneSeen++; end
    vectors++; if (doneSeen != 0) begin miscompares++; $display("[TB] FAIL mid_no_done: got %0d done cycles expected 0", doneSeen); end
    vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_release: got ready=%0d busy=%0d expected 1 0", cmd_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_trim();
    test_abort();
    test_idle();
    test_full_move();
    test_zero_pulses();
    test_clamp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
